// File: rtl/aes_round_tail.sv
// AES-128 round tail: ShiftRows, MixColumns (bypassed on the final round), AddRoundKey.
// Latency: one cycle from input transfer to registered result. Set AES_SKID_EN for a registered in_ready.
// Backpressure: valid/ready; AES_SKID_EN adds a one-entry skid buffer so out_ready has no path to in_ready.
module aes_round_tail (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] in_key,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         out_last
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte k sits at [127-8k -: 8] with row k%4 and column k/4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            res[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
        end
        return res;
    endfunction

    logic [127:0] sr_state;
    logic [127:0] mc_state;
    logic [127:0] rnd_state;
    logic         in_xfer;
    logic         out_xfer;

    always_comb begin
        sr_state  = shift_rows(in_state);
        mc_state  = mix_columns(sr_state);
        rnd_state = (in_last ? sr_state : mc_state) ^ in_key;
    end

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

`ifdef AES_SKID_EN
    logic         skid_vld;
    logic [127:0] skid_state;
    logic         skid_last;
    logic         in_ready_q;

    assign in_ready = in_ready_q;

    // The skid entry is only ever filled while out_valid is held, so draining it keeps out_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_state  <= '0;
            out_last   <= 1'b0;
            skid_vld   <= 1'b0;
            skid_state <= '0;
            skid_last  <= 1'b0;
            in_ready_q <= 1'b1;
        end else if (skid_vld) begin
            if (out_ready) begin
                out_state  <= skid_state;
                out_last   <= skid_last;
                skid_vld   <= 1'b0;
                in_ready_q <= 1'b1;
            end
        end else if (in_xfer) begin
            if (!out_valid || out_ready) begin
                out_valid <= 1'b1;
                out_state <= rnd_state;
                out_last  <= in_last;
            end else begin
                skid_vld   <= 1'b1;
                skid_state <= rnd_state;
                skid_last  <= in_last;
                in_ready_q <= 1'b0;
            end
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end
`else
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_state <= '0;
            out_last  <= 1'b0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            out_state <= rnd_state;
            out_last  <= in_last;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_aes_round_tail.sv
// Directed-vector bench for aes_round_tail: known-answer table, backpressure, streaming and reset.
module tb_aes_round_tail;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_state = '0;
    logic [127:0] in_key = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_state;
    logic         out_last;

    always #5 clk = ~clk;

    aes_round_tail dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_key    (in_key),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .out_last  (out_last)
    );

    typedef struct {
        logic [127:0] s;
        logic [127:0] k;
        logic         l;
        logic [127:0] e;
    } vec_t;

    vec_t         tbl[7];
    logic [128:0] sbq[$];
    int           total = 0;
    int           bad = 0;
    int           delivered = 0;

    task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] key, input logic fin);
        logic [7:0]   b[16];
        logic [7:0]   sr[16];
        logic [7:0]   o[16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                sr[4*c+rr] = b[4*((c+rr)%4)+rr];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                o[4*c+rr] = fin ? sr[4*c+rr]
                               : gmul(sr[4*c+rr], 8'h02) ^ gmul(sr[4*c+(rr+1)%4], 8'h03)
                                 ^ sr[4*c+(rr+2)%4] ^ sr[4*c+(rr+3)%4];
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = o[i] ^ key[127-8*i -: 8];
        return res;
    endfunction

    // One clock: drive at posedge+1, score at posedge+2, return at next posedge+1.
    task automatic cyc(input logic iv, input logic [127:0] s, input logic [127:0] k, input logic l,
                       input logic ordy, output logic acc, output logic rdy);
        logic [128:0] exp;
        in_valid  = iv;
        in_state  = s;
        in_key    = k;
        in_last   = l;
        out_ready = ordy;
        #1;
        rdy = in_ready;
        acc = iv && in_ready;
        if (out_valid && out_ready) begin
            delivered++;
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got %h expected no transfer", {out_last, out_state});
            end else begin
                exp = sbq.pop_front();
                check("scoreboard", {out_last, out_state}, exp);
            end
        end
        if (acc) sbq.push_back({l, model(s, k, l)});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    logic         acc, rdy, v2_done, exp_rdy;
    logic [127:0] rs, rk;
    logic         rl;
    int           d0;

    initial begin
        tbl[0] = '{128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0,
                   128'ha49c7ff2689f352b6b5bea43026a5049};
        tbl[1] = '{128'he9098972cb31075f3d327d94af2e2cb5, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1,
                   128'h3925841d02dc09fbdc118597196a0b32};
        tbl[2] = '{128'h00112233445566778899aabbccddeeff, 128'h0, 1'b1,
                   128'h0055aaff4499ee3388dd2277cc1166bb};
        tbl[3] = '{{4{32'hdb135345}}, 128'h0, 1'b0, {4{32'h8e4da1bc}}};
        tbl[4] = '{{4{32'hf20a225c}}, 128'h0, 1'b0, {4{32'h9fdc589d}}};
        tbl[5] = '{128'h0, 128'h0123456789abcdeffedcba9876543210, 1'b0,
                   128'h0123456789abcdeffedcba9876543210};
        tbl[6] = '{{128{1'b1}}, {128{1'b1}}, 1'b0, 128'h0};

        // Reset state, asserted before any clock edge.
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_state", out_state, 128'h0);
        check("rst_out_last", out_last, 1'b0);
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rdy_after_reset", in_ready, 1'b1);

        // Known-answer table with out_ready held high.
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, tbl[i].s, tbl[i].k, tbl[i].l, 1'b1, acc, rdy);
            check("tbl_accept", acc, 1'b1);
            check("tbl_out_valid", out_valid, 1'b1);
            check("tbl_out_state", out_state, tbl[i].e);
            check("tbl_out_last", out_last, tbl[i].l);
        end
        cyc(1'b0, '0, '0, 1'b0, 1'b1, acc, rdy);
        check("drain_valid_low", out_valid, 1'b0);

        // Backpressure: round 1 then round 10 with the first result stalled three cycles.
        cyc(1'b1, tbl[0].s, tbl[0].k, tbl[0].l, 1'b0, acc, rdy);
        check("bp_first_accept", acc, 1'b1);
        v2_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_held_valid", out_valid, 1'b1);
            check("bp_held_state", out_state, tbl[0].e);
            check("bp_held_last", out_last, 1'b0);
`ifdef AES_SKID_EN
            exp_rdy = (i == 0);
`else
            exp_rdy = 1'b0;
`endif
            cyc(!v2_done, tbl[1].s, tbl[1].k, tbl[1].l, 1'b0, acc, rdy);
            check("bp_in_ready", rdy, exp_rdy);
            if (acc) v2_done = 1'b1;
        end
        check("bp_held_state_end", out_state, tbl[0].e);
        d0 = delivered;
        for (int j = 0; j < 8 && (sbq.size() > 0 || !v2_done); j++) begin
            cyc(!v2_done, tbl[1].s, tbl[1].k, tbl[1].l, 1'b1, acc, rdy);
            if (acc) v2_done = 1'b1;
        end
        check("bp_delivered", delivered - d0, 2);
        check("bp_second_accepted", v2_done, 1'b1);
        check("bp_valid_low", out_valid, 1'b0);

        // Streaming: ten back-to-back random rounds.
        d0 = delivered;
        for (int i = 0; i < 10; i++) begin
            rs = {$urandom(), $urandom(), $urandom(), $urandom()};
            rk = {$urandom(), $urandom(), $urandom(), $urandom()};
            rl = 1'($urandom_range(0, 1));
            cyc(1'b1, rs, rk, rl, 1'b1, acc, rdy);
            check("stream_accept", acc, 1'b1);
            check("stream_valid", out_valid, 1'b1);
        end
        cyc(1'b0, '0, '0, 1'b0, 1'b1, acc, rdy);
        check("stream_delivered", delivered - d0, 10);
        check("stream_queue_empty", sbq.size(), 0);
        check("stream_valid_low", out_valid, 1'b0);

        // Reset while a result is held.
        cyc(1'b1, tbl[0].s, tbl[0].k, tbl[0].l, 1'b0, acc, rdy);
        cyc(1'b0, '0, '0, 1'b0, 1'b0, acc, rdy);
        check("pre_reset_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_state", out_state, 128'h0);
        check("async_rst_last", out_last, 1'b0);
        sbq.delete();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, '0, '0, 1'b0, 1'b1, acc, rdy);
            check("post_reset_no_output", out_valid, 1'b0);
        end
        check("post_reset_rdy", in_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_round_tail.md
AES_ROUND_TAIL -- requirements
Module: aes_round_tail

Interface
REQ-001 Parameters: none; all widths are fixed by AES-128.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream SubBytes result and key are valid this cycle.
REQ-005 in_ready  output  1  stage accepts input this cycle.
REQ-006 in_state  input  128  post-SubBytes state; byte k at [127-8k -: 8], row k%4, column k/4.
REQ-007 in_key  input  128  round key, same byte order as in_state.
REQ-008 in_last  input  1  final round: skip MixColumns.
REQ-009 out_valid  output  1  out_state/out_last hold a completed round.
REQ-010 out_ready  input  1  downstream accepts output this cycle.
REQ-011 out_state  output  128  round result after ShiftRows, MixColumns (unless last) and AddRoundKey.
REQ-012 out_last  output  1  registered copy of in_last for the result.

Function
REQ-013 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-014 ShiftRows: row r rotated left by r bytes (r=0..3).
REQ-015 MixColumns: each column times {02,03,01,01} circulant over GF(2^8), reduction polynomial 0x11B; xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0), truncated to 8 bits.
REQ-016 in_last=1: ShiftRows output goes directly to AddRoundKey.
REQ-017 AddRoundKey: 128-bit XOR with in_key.
REQ-018 Latency: result is registered and presented one cycle after the input transfer.
REQ-019 out_state, out_last and out_valid change only on an input transfer, an output transfer or reset.
REQ-020 Held output (out_valid=1, out_ready=0): out_state/out_last stable until transferred.
REQ-021 Simultaneous input and output transfer in one cycle: new result replaces old, out_valid stays 1; no bubble, no loss.
REQ-022 Output transfer with no input transfer: out_valid deasserts next cycle.
REQ-023 Stage is stateless between transactions: no FSM, no dependence on earlier rounds.
REQ-024 Inputs are sampled only on an input transfer; inputs are ignored while in_valid=0.

Reset
REQ-025 rst_n low: out_valid=0, out_last=0, out_state=128'h0 immediately, independent of clk.
REQ-026 Reset mid-transaction discards the held result; no output transfer occurs for it after release.
REQ-027 in_ready is 1 from the first clock edge after rst_n is released (with AES_SKID_EN, REQ-029 governs).

Configuration
REQ-028 Macro AES_SKID_EN undefined: in_ready = !out_valid || out_ready (combinational path from out_ready).
REQ-029 AES_SKID_EN defined:
- in_ready is a register and has no combinational path from out_ready.
- A one-entry skid buffer captures an input transfer that coincides with a stalled output.
- Full throughput is sustained; order is preserved.
- in_ready=0 only while the skid entry is occupied.
- Reset clears the skid entry and sets in_ready=1.
REQ-030 Both builds produce identical output transfer sequences for identical input sequences and out_ready patterns when out_ready is held 1.

Verification
REQ-031 FIPS-197 App. B round 1: in_state=d42711aee0bf98f1b8b45de51e415230, in_key=a0fafe1788542cb123a339392a6c7605, in_last=0 -> out_state=a49c7ff2689f352b6b5bea43026a5049 one cycle later.
REQ-032 Round 10: in_state=e9098972cb31075f3d327d94af2e2cb5, in_key=d014f9a8c9ee2589e13f0cc8b6630ca6, in_last=1 -> out_state=3925841d02dc09fbdc118597196a0b32, out_last=1.
REQ-033 Backpressure test:
- Stimulus: REQ-031 vector, then REQ-032 vector back-to-back, with out_ready=0 for 3 cycles after the first result.
- Response: first result held stable; no loss or duplication.
- Response: both results delivered in order once out_ready=1.
- With AES_SKID_EN, in_ready drops only after the second vector occupies the skid entry.
REQ-034 Streaming: 10 back-to-back transfers with out_ready=1 -> 10 outputs on consecutive cycles, each matching the software model.
REQ-035 Reset: rst_n pulsed low while out_valid=1 and out_ready=0 -> out_valid=0 and out_state=0 immediately; no stale output after release.
